// File: rtl/fetch_if.sv
// Instruction-memory request/ready bus between the fetch stage and instruction memory.
interface fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, runs the memory handshake, keeps a one-word
// skid buffer for decode stalls and squashes wrong-path responses after a redirect.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  fetch_if.master     mem,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] target_q, target_d;

  logic [31:0] br_tgt;
  logic [1:0]  unused_tgt_lsbs;
  logic        consumed;

  assign br_tgt          = {branch_target_i[31:2], 2'b00};
  assign unused_tgt_lsbs = branch_target_i[1:0];
  assign consumed        = valid_q & ~stall_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    insn_d    = insn_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    target_d  = target_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (branch_taken_i) begin
          valid_d = 1'b0;
          insn_d  = NOP_INSN;
          if (mem.mem_ready) begin
            addr_d = br_tgt;
          end else begin
            // Request already issued: address must stay put until it completes.
            target_d = br_tgt;
            state_d  = StDrain;
          end
        end else if (mem.mem_ready) begin
          addr_d = addr_q + 32'd4;
          if (!valid_q || !stall_i) begin
            insn_d  = mem.mem_rdata;
            pc_d    = addr_q;
            valid_d = 1'b1;
          end else begin
            skid_d    = mem.mem_rdata;
            skid_pc_d = addr_q;
            state_d   = StHold;
          end
        end else if (consumed) begin
          valid_d = 1'b0;
          insn_d  = NOP_INSN;
        end
      end
      StHold: begin
        if (branch_taken_i) begin
          valid_d = 1'b0;
          insn_d  = NOP_INSN;
          addr_d  = br_tgt;
          state_d = StFetch;
        end else if (!stall_i) begin
          insn_d  = skid_q;
          pc_d    = skid_pc_q;
          valid_d = 1'b1;
          state_d = StFetch;
        end
      end
      StDrain: begin
        // A fresh redirect only retargets; any response this cycle is wrong-path anyway.
        if (branch_taken_i) begin
          target_d = br_tgt;
        end else if (mem.mem_ready) begin
          addr_d  = target_q;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= RESET_PC;
      insn_q    <= NOP_INSN;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      skid_q    <= 32'h0;
      skid_pc_q <= 32'h0;
      target_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      insn_q    <= insn_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      target_q  <= target_d;
    end
  end

  assign mem.mem_req  = (state_q == StFetch) || (state_q == StDrain);
  assign mem.mem_addr = addr_q;
  assign instruction_o = insn_q;
  assign pc_o          = pc_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based model of the fetch stream.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] insn, pc;
  logic        valid;
  logic [31:0] w_insn, w_pc;
  logic        w_valid;

  fetch_if mif ();
  fetch_if wif ();

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0000), .NOP_INSN(NOP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .mem             (mif.master),
    .instruction_o   (insn),
    .pc_o            (pc),
    .valid_o         (valid)
  );

  // Second instance exercises the address wrap with a zero-wait memory returning addr.
  assign wif.mem_ready = 1'b1;
  assign wif.mem_rdata = wif.mem_addr;
  fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSN(NOP)) u_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (1'b0),
    .branch_taken_i  (1'b0),
    .branch_target_i (32'h0),
    .mem             (wif.master),
    .instruction_o   (w_insn),
    .pc_o            (w_pc),
    .valid_o         (w_valid)
  );

  int checks = 0;
  int errors = 0;
  bit hash_mode = 1'b0;

  // Model: the words awaiting decode (presented word first, at most one behind it).
  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];
  logic        m_started;
  logic        m_drain;
  logic [31:0] m_addr;
  logic [31:0] m_target;
  logic        m_ready;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return hash_mode ? ({a[15:0], a[31:16]} ^ 32'hC3A5_1E0F) : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_data.delete();
    m_started = 1'b0;
    m_drain   = 1'b0;
    m_addr    = 32'h0;
    m_target  = 32'h0;
  endtask

  task automatic model_update();
    logic req, comp, cons;
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    req  = q_pc.size() < 2;
    comp = req && m_ready;
    cons = q_pc.size() > 0 && !stall;
    if (br) begin
      q_pc.delete();
      q_data.delete();
      if (m_drain) begin
        m_target = {tgt[31:2], 2'b00};
      end else if (req && !m_ready) begin
        m_drain  = 1'b1;
        m_target = {tgt[31:2], 2'b00};
      end else begin
        m_addr = {tgt[31:2], 2'b00};
      end
    end else if (m_drain) begin
      if (comp) begin
        m_drain = 1'b0;
        m_addr  = m_target;
      end
    end else begin
      if (cons) begin
        void'(q_pc.pop_front());
        void'(q_data.pop_front());
      end
      if (comp) begin
        q_pc.push_back(m_addr);
        q_data.push_back(mem_word(m_addr));
        m_addr = m_addr + 32'd4;
      end
    end
  endtask

  task automatic compare();
    logic ev;
    ev = q_pc.size() > 0;
    chk("m_valid", {31'h0, valid}, {31'h0, ev});
    chk("m_insn", insn, ev ? q_data[0] : NOP);
    if (ev) chk("m_pc", pc, q_pc[0]);
    chk("m_req", {31'h0, mif.mem_req}, {31'h0, m_started && q_pc.size() < 2});
    chk("m_addr", mif.mem_addr, m_addr);
  endtask

  // Called at a negedge: drive inputs, advance one clock, then check at the next negedge.
  task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
    stall         = s;
    br            = b;
    tgt           = t;
    m_ready       = r;
    mif.mem_ready = r;
    mif.mem_rdata = mem_word(mif.mem_addr);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  initial begin
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_insn", insn, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    chk("rst_req", {31'h0, mif.mem_req}, 32'h0);
    rst_n = 1'b1;

    // Zero-wait streaming from reset, addr returned as data.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_req", {31'h0, mif.mem_req}, 32'h1);
    chk("t1_addr0", mif.mem_addr, 32'h0);
    chk("wrap_addr0", wif.mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_insn0", insn, 32'h0);
    chk("t1_addr4", mif.mem_addr, 32'h4);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", wif.mem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_insn4", insn, 32'h4);
    chk("t1_pc4", pc, 32'h4);
    chk("wrap_pc1", w_pc, 32'h0);

    // Stall with skid full: word at 8 parks, memory idles, then drains in order.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t2_hold_req", {31'h0, mif.mem_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t2_held", insn, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_skid_insn", insn, 32'h8);
    chk("t2_skid_pc", pc, 32'h8);
    chk("t2_resume", mif.mem_addr, 32'hC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_insnC", insn, 32'hC);

    // Redirect while a request waits on memory.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h103, 1'b0);
    chk("t3_nop", insn, NOP);
    chk("t3_keep", mif.mem_addr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_valid", {31'h0, valid}, 32'h0);
    chk("t3_tgt", mif.mem_addr, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_pc", pc, 32'h100);

    // Redirect during HOLD drops the skid word.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    chk("t4_valid", {31'h0, valid}, 32'h0);
    chk("t4_addr", mif.mem_addr, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_pc", pc, 32'h40);

    // Randomized traffic against the model.
    hash_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of a drain.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h300, 1'b0);
    chk("t6_drain_req", {31'h0, mif.mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'h0, valid}, 32'h0);
    chk("t6_insn", insn, NOP);
    chk("t6_pc", pc, 32'h0);
    chk("t6_addr", mif.mem_addr, 32'h0);
    chk("t6_req", {31'h0, mif.mem_req}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_first", mif.mem_addr, 32'h0);
    chk("t6_first_req", {31'h0, mif.mem_req}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
